fetch_queue_unit: RTL and testbench
===================================

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, byte address loaded into the PC on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 PC  output  32  byte address of the current fetch, driven straight from the PC register to instruction memory.
REQ-005 Instr  input  32  instruction word returned combinationally by instruction memory for PC.
REQ-006 Stall  input  1  when 1, fetch is suppressed and the PC holds.
REQ-007 Redirect  input  1  taken branch or jump from the execute path; flushes the queue.
REQ-008 RedirectPC  input  32  target byte address, valid when Redirect=1.
REQ-009 DecReady  input  1  decoder accepts the head entry this cycle.
REQ-010 DecValid  output  1  head entry is valid.
REQ-011 DecInstr  output  32  instruction at the queue head.
REQ-012 DecPC  output  32  PC of the instruction at the queue head.
REQ-013 FetchCount  output  2  queue occupancy, 0..2.
REQ-014 AlignErr  output  1  one-cycle registered pulse for a misaligned redirect target.

Function
REQ-015 The queue SHALL be a 2-entry registered FIFO of {PC, Instr} pairs; DecInstr, DecPC and DecValid come from registers only.
REQ-016 DecValid SHALL equal (FetchCount != 0); DecInstr and DecPC are don't-care when DecValid=0.
REQ-017 Pop SHALL occur when DecValid=1 and DecReady=1 and Redirect=0.
REQ-018 Push (fetch) SHALL occur when Redirect=0, Stall=0 and (FetchCount<2 or pop). The pushed entry is {PC, Instr}, and PC is updated to PC+4 with wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 Simultaneous push and pop SHALL leave FetchCount unchanged and preserve order; a push with FetchCount=2 is legal only with a same-cycle pop.
REQ-020 With no push, PC SHALL hold its value.
REQ-021 Redirect SHALL have highest priority. That cycle, the queue empties (FetchCount=0 next cycle), there is no push and no pop, and PC <= {RedirectPC[31:2], 2'b00}; Stall is ignored.
REQ-022 AlignErr SHALL be 1 for exactly the cycle after a Redirect with RedirectPC[1:0] != 0, and 0 otherwise.
REQ-023 Latency: an instruction fetched at edge N SHALL appear on DecInstr after edge N; DecValid deasserts after edge N+1 if popped at edge N+1.
REQ-024 Stall=1 SHALL NOT block pops; the queue drains while stalled.
REQ-025 FetchCount SHALL never exceed 2 nor underflow below 0; a pop with FetchCount=0 cannot occur by construction.

Reset
REQ-026 While rst=1: PC=RESET_PC, FetchCount=0, DecValid=0, AlignErr=0, DecInstr=0, DecPC=0, asynchronously.
REQ-027 rst asserted mid-operation SHALL discard all queued entries and any pending redirect immediately.
REQ-028 The first fetch SHALL occur at the first rising edge with rst=0 (subject to Stall and Redirect).

Verification
REQ-029 Reset release, Stall=0, DecReady=0, memory holding words A,B,C at PCs 0,4,8 -> edge1: DecPC=0, DecInstr=A, count=1; edge2: count=2, PC=8; edge3: count=2, PC stays 8.
REQ-030 Full queue, DecReady=1 continuously -> one pop and one push per cycle, count stays 2, DecPC sequence 0,4,8,12 with no gaps or duplicates.
REQ-031 Redirect=1, RedirectPC=32'h40 with count=2 -> next cycle count=0, DecValid=0, PC=32'h40, AlignErr=0; the following cycle DecPC=32'h40.
REQ-032 Redirect with RedirectPC=32'h46 -> PC=32'h44, and AlignErr=1 for one cycle then 0.
REQ-033 Stall=1 with count=2 and DecReady=1 -> queue drains to 0 in 2 cycles, PC holds, DecValid=0 thereafter; on Stall=0, fetch resumes from the held PC.
REQ-034 RESET_PC=32'hFFFF_FFFC, no backpressure -> DecPC sequence FFFF_FFFC, 0000_0000, 0000_0004; rst pulsed mid-sequence -> count=0 and PC=RESET_PC immediately.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage with a 2-entry registered queue of {PC, Instr} pairs
// feeding the decoder; redirects flush the queue and realign the PC.
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  input  logic [31:0] Instr,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        DecReady,
  output logic        DecValid,
  output logic [31:0] DecInstr,
  output logic [31:0] DecPC,
  output logic [1:0]  FetchCount,
  output logic        AlignErr
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Entry 0 is always the queue head.
  entry_t      head_q, head_d, tail_q, tail_d;
  entry_t      fetched;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic        align_err_q, align_err_d;
  logic        push, pop;

  assign fetched = '{pc: pc_q, instr: Instr};
  assign pop     = (count_q != 2'd0) && DecReady && !Redirect;
  assign push    = !Redirect && !Stall && ((count_q != 2'd2) || pop);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pc_d        = pc_q;
    align_err_d = Redirect && (RedirectPC[1:0] != 2'b00);

    if (Redirect) begin
      count_d = 2'd0;
      pc_d    = {RedirectPC[31:2], 2'b00};
    end else begin
      if (push) pc_d = pc_q + 32'd4;
      case ({push, pop})
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) head_d = fetched;
          else                 tail_d = fetched;
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new entry lands behind whatever survives the pop.
          if (count_q == 2'd1) begin
            head_d = fetched;
          end else begin
            head_d = tail_q;
            tail_d = fetched;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the queue entries are reset too, because the decoder-facing outputs must read zero during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 2'd0;
      pc_q        <= RESET_PC;
      align_err_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pc_q        <= pc_d;
      align_err_q <= align_err_d;
    end
  end

  assign PC         = pc_q;
  assign DecValid   = (count_q != 2'd0);
  assign DecInstr   = head_q.instr;
  assign DecPC      = head_q.pc;
  assign FetchCount = count_q;
  assign AlignErr   = align_err_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a table of per-cycle vectors plus
// hand-written sequences for PC wrap-around and asynchronous mid-run reset.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, dec_ready;
  logic [31:0] redirect_pc;

  logic [31:0] pc, instr, dec_instr, dec_pc;
  logic        dec_valid, align_err;
  logic [1:0]  fetch_count;

  logic [31:0] w_pc, w_instr, w_dec_instr, w_dec_pc;
  logic        w_dec_valid, w_align_err;
  logic [1:0]  w_fetch_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory model: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A5A};
  endfunction

  assign instr   = imem(pc);
  assign w_instr = imem(w_pc);

  fetch_queue_unit dut (
    .clk(clk), .rst(rst), .PC(pc), .Instr(instr), .Stall(stall),
    .Redirect(redirect), .RedirectPC(redirect_pc), .DecReady(dec_ready),
    .DecValid(dec_valid), .DecInstr(dec_instr), .DecPC(dec_pc),
    .FetchCount(fetch_count), .AlignErr(align_err)
  );

  fetch_queue_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .PC(w_pc), .Instr(w_instr), .Stall(stall),
    .Redirect(redirect), .RedirectPC(redirect_pc), .DecReady(dec_ready),
    .DecValid(w_dec_valid), .DecInstr(w_dec_instr), .DecPC(w_dec_pc),
    .FetchCount(w_fetch_count), .AlignErr(w_align_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        rdy;
    logic [1:0]  cnt;
    logic [31:0] pc;
    logic [31:0] dpc;
    logic        al;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    //            stall redir rpc         rdy  cnt   pc          dpc         al
    vecs[0]  = '{1'b0, 1'b0, 32'h0,      1'b0, 2'd1, 32'h04,     32'h00,     1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,      1'b0, 2'd2, 32'h08,     32'h00,     1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,      1'b0, 2'd2, 32'h08,     32'h00,     1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,      1'b1, 2'd2, 32'h0C,     32'h04,     1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,      1'b1, 2'd2, 32'h10,     32'h08,     1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,      1'b1, 2'd2, 32'h14,     32'h0C,     1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h40,     1'b0, 2'd0, 32'h40,     32'h0,      1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,      1'b0, 2'd1, 32'h44,     32'h40,     1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,      1'b0, 2'd2, 32'h48,     32'h40,     1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,      1'b1, 2'd1, 32'h48,     32'h44,     1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0,      1'b1, 2'd0, 32'h48,     32'h0,      1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h0,      1'b1, 2'd0, 32'h48,     32'h0,      1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,      1'b0, 2'd1, 32'h4C,     32'h48,     1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'h46,     1'b1, 2'd0, 32'h44,     32'h0,      1'b1};
    vecs[14] = '{1'b0, 1'b0, 32'h0,      1'b0, 2'd1, 32'h48,     32'h44,     1'b0};
    vecs[15] = '{1'b1, 1'b1, 32'h103,    1'b1, 2'd0, 32'h100,    32'h0,      1'b1};
    vecs[16] = '{1'b1, 1'b0, 32'h0,      1'b0, 2'd0, 32'h100,    32'h0,      1'b0};
    vecs[17] = '{1'b0, 1'b0, 32'h0,      1'b1, 2'd1, 32'h104,    32'h100,    1'b0};
    vecs[18] = '{1'b0, 1'b0, 32'h0,      1'b1, 2'd1, 32'h108,    32'h104,    1'b0};

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    #2;
    check("rst_pc",     pc,          32'h0);
    check("rst_count",  fetch_count, 32'd0);
    check("rst_valid",  dec_valid,   32'd0);
    check("rst_align",  align_err,   32'd0);
    check("rst_decpc",  dec_pc,      32'h0);
    check("rst_instr",  dec_instr,   32'h0);
    check("rst_w_pc",   w_pc,        32'hFFFF_FFFC);

    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      stall       = vecs[i].stall;
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      dec_ready   = vecs[i].rdy;
      @(posedge clk); #1;
      check($sformatf("v%0d_count", i), fetch_count, vecs[i].cnt);
      check($sformatf("v%0d_valid", i), dec_valid, vecs[i].cnt != 2'd0);
      check($sformatf("v%0d_pc", i),    pc,        vecs[i].pc);
      check($sformatf("v%0d_align", i), align_err, vecs[i].al);
      if (vecs[i].cnt != 2'd0) begin
        check($sformatf("v%0d_decpc", i),    dec_pc,    vecs[i].dpc);
        check($sformatf("v%0d_decinstr", i), dec_instr, imem(vecs[i].dpc));
      end
    end

    // Wrap-around sequence on the high RESET_PC instance, no backpressure.
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check("wrap0_decpc", w_dec_pc, 32'hFFFF_FFFC);
    check("wrap0_instr", w_dec_instr, imem(32'hFFFF_FFFC));
    check("wrap0_pc",    w_pc, 32'h0000_0000);
    @(posedge clk); #1;
    check("wrap1_decpc", w_dec_pc, 32'h0000_0000);
    check("wrap1_pc",    w_pc, 32'h0000_0004);
    @(posedge clk); #1;
    check("wrap2_decpc", w_dec_pc, 32'h0000_0004);
    check("wrap2_count", w_fetch_count, 32'd1);

    // Asynchronous reset mid-sequence, asserted between clock edges.
    #2;
    rst = 1'b1;
    #1;
    check("arst_w_count", w_fetch_count, 32'd0);
    check("arst_w_pc",    w_pc, 32'hFFFF_FFFC);
    check("arst_w_valid", w_dec_valid, 32'd0);
    check("arst_w_decpc", w_dec_pc, 32'h0);
    check("arst_count",   fetch_count, 32'd0);
    check("arst_pc",      pc, 32'h0);
    @(posedge clk); #1;
    check("arst_hold_pc", w_pc, 32'hFFFF_FFFC);
    rst = 1'b0;
    @(posedge clk); #1;
    check("arst_refetch", w_dec_pc, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
